// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for a 640x480 @ 60 Hz display path.
//
// Produces the pixel position (DrawX/DrawY), the visible-area flag (blank, 1 = visible),
// active-low hs/vs sync pulses, a constant-zero composite sync, a one-enable-cycle frame
// strobe and an 8-bit wrapping frame counter. Every output is a register; the decode for
// hs/vs/blank is taken from the next counter value so all outputs describe the same position.
//
// Ports:
//   vga_clk     - pixel-domain clock, rising edge
//   reset       - asynchronous, active-high
//   pix_en      - pixel advance enable; every register holds while low
//   DrawX/DrawY - horizontal/vertical position
//   blank       - 1 when (DrawX, DrawY) is inside the visible area
//   hs/vs       - horizontal/vertical sync, active-low
//   sync        - composite sync for the DAC, tied low
//   frame_start - high for the enable cycle in which the position wraps to (0, 0)
//   frame_count - completed frames, modulo 256
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The 10-bit counters cannot represent larger rasters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] HMax       = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax       = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hc_q == HMax);
    v_wrap = (vc_q == VMax);

    hc_d = h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? 10'd0 : vc_q + 10'd1;
    end

    // Decode the position being entered so the registered flags line up with DrawX/DrawY.
    blank_d = (hc_d < HVis) && (vc_d < VVis);
    hs_d    = !((hc_d >= HSyncStart) && (hc_d <= HSyncEnd));
    vs_d    = !((vc_d >= VSyncStart) && (vc_d <= VSyncEnd));

    frame_start_d = h_wrap && v_wrap;
    frame_count_d = frame_count_q + {7'd0, frame_start_d};
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else if (pix_en) begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign sync        = 1'b0;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Two instances share clock, reset and enable: one with the
// default 800x525 raster (line-level checks) and one with a tiny 12x9 raster so whole
// frames and 256-frame counter wrap fit in a short run. A behavioural model pushes the
// expected output of every clock onto a per-instance queue; each scenario pops and compares.
module tb_vga_timing_gen;

  localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
  localparam int SHV = 8, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVV = 6, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHV + SHF + SHS + SHB;  // 12
  localparam int SVT = SVV + SVF + SVS + SVB;  // 9

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       sync;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  localparam out_t RST = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, sync: 1'b0,
                           fs: 1'b0, fc: 8'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b1;

  logic [9:0] dx_d, dy_d, dx_s, dy_s;
  logic       bl_d, hs_d, vs_d, sy_d, fs_d, bl_s, hs_s, vs_s, sy_s, fs_s;
  logic [7:0] fc_d, fc_s;
  out_t obs_d, obs_s;

  assign obs_d = {dx_d, dy_d, bl_d, hs_d, vs_d, sy_d, fs_d, fc_d};
  assign obs_s = {dx_s, dy_s, bl_s, hs_s, vs_s, sy_s, fs_s, fc_s};

  always #5 clk = ~clk;

  vga_timing_gen u_dut_d (
    .vga_clk(clk), .reset(rst), .pix_en(pix_en), .DrawX(dx_d), .DrawY(dy_d), .blank(bl_d),
    .hs(hs_d), .vs(vs_d), .sync(sy_d), .frame_start(fs_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) u_dut_s (
    .vga_clk(clk), .reset(rst), .pix_en(pix_en), .DrawX(dx_s), .DrawY(dy_s), .blank(bl_s),
    .hs(hs_s), .vs(vs_s), .sync(sy_s), .frame_start(fs_s), .frame_count(fc_s)
  );

  int n_total = 0;
  int n_pass  = 0;
  out_t md, ms;       // model state for each instance
  out_t q_d[$], q_s[$];
  out_t ed, es;

  function automatic out_t decode(input logic [9:0] x, input logic [9:0] y, input logic fs,
                                  input logic [7:0] fc, input int hv, input int hf,
                                  input int hsw, input int vv, input int vf, input int vsw);
    out_t o;
    o.x     = x;
    o.y     = y;
    o.blank = (int'(x) < hv) && (int'(y) < vv);
    o.hs    = !((int'(x) >= hv + hf) && (int'(x) < hv + hf + hsw));
    o.vs    = !((int'(y) >= vv + vf) && (int'(y) < vv + vf + vsw));
    o.sync  = 1'b0;
    o.fs    = fs;
    o.fc    = fc;
    return o;
  endfunction

  function automatic out_t advance(input out_t c, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb);
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    logic hw = (int'(c.x) == ht - 1);
    logic vw = (int'(c.y) == vt - 1);
    logic [9:0] nx = hw ? 10'd0 : c.x + 10'd1;
    logic [9:0] ny = hw ? (vw ? 10'd0 : c.y + 10'd1) : c.y;
    logic nfs = hw && vw;
    return decode(nx, ny, nfs, c.fc + (nfs ? 8'd1 : 8'd0), hv, hf, hsw, vv, vf, vsw);
  endfunction

  // Drive one clock with the given enable, queueing the expected outputs after the edge.
  task automatic cycle(input logic en);
    out_t nd, ns;
    pix_en = en;
    nd = en ? advance(md, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB) : md;
    ns = en ? advance(ms, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB) : ms;
    q_d.push_back(nd);
    q_s.push_back(ns);
    md = nd;
    ms = ns;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    md = RST;
    ms = RST;
    q_d.delete();
    q_s.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (obs_d !== RST) $display("FAIL reset_d got %h want %h", obs_d, RST);
    else n_pass++;
    n_total++;
    if (obs_s !== RST) $display("FAIL reset_s got %h want %h", obs_s, RST);
    else n_pass++;
    #2 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 640; i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL reset_seq_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL reset_seq_s got %h want %h", obs_s, es);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if ({dx_d, dy_d, bl_d} !== {10'd1, 10'd0, 1'b1})
          $display("FAIL first_edge got x=%0d y=%0d blank=%b want x=1 y=0 blank=1",
                   dx_d, dy_d, bl_d);
        else n_pass++;
      end
    end
    n_total++;
    if ({dx_d, bl_d, hs_d} !== {10'd640, 1'b0, 1'b1})
      $display("FAIL x640 got x=%0d blank=%b hs=%b want x=640 blank=0 hs=1", dx_d, bl_d, hs_d);
    else n_pass++;
  endtask

  task automatic test_line_sweep();
    logic prev_hs, prev_bl;
    logic [9:0] prev_x;
    int fall_x = -1, rise_x = -1, hs_low = 0, bl_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      prev_x = dx_d;
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL line_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL line_s got %h want %h", obs_s, es);
      else n_pass++;
    end
    n_total++;
    if ({prev_x, dx_d, dy_d} !== {10'd799, 10'd0, 10'd1})
      $display("FAIL line_wrap got %0d->(%0d,%0d) want 799->(0,1)", prev_x, dx_d, dy_d);
    else n_pass++;
    prev_hs = hs_d;
    for (int i = 0; i < 800; i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL line_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL line_s got %h want %h", obs_s, es);
      else n_pass++;
      if (prev_hs && !hs_d) fall_x = int'(dx_d);
      if (!prev_hs && hs_d) rise_x = int'(dx_d);
      if (!hs_d) hs_low++;
      if (bl_d) bl_cnt++;
      prev_hs = hs_d;
    end
    prev_bl = bl_d;
    n_total++;
    if (fall_x != 656) $display("FAIL hs_fall got x=%0d want 656", fall_x);
    else n_pass++;
    n_total++;
    if (rise_x != 752) $display("FAIL hs_rise got x=%0d want 752", rise_x);
    else n_pass++;
    n_total++;
    if (hs_low != 96) $display("FAIL hs_width got %0d want 96", hs_low);
    else n_pass++;
    n_total++;
    if (bl_cnt != 640 || prev_bl !== 1'b1)
      $display("FAIL line_visible got %0d want 640", bl_cnt);
    else n_pass++;
  endtask

  task automatic test_frame_sweep();
    int vs_low = 0, bl_cnt = 0, bl_bad = 0, fs_cnt = 0;
    logic [7:0] fc0;
    for (int i = 0; i < 200 && !ms.fs; i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL frame_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL frame_s got %h want %h", obs_s, es);
      else n_pass++;
    end
    n_total++;
    if ({dx_s, dy_s, fs_s} !== {10'd0, 10'd0, 1'b1})
      $display("FAIL frame_align got (%0d,%0d) fs=%b want (0,0) fs=1", dx_s, dy_s, fs_s);
    else n_pass++;
    fc0 = fc_s;
    for (int i = 0; i < SHT * SVT; i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL frame_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL frame_s got %h want %h", obs_s, es);
      else n_pass++;
      if (!vs_s) vs_low++;
      if (bl_s) bl_cnt++;
      if (bl_s && dy_s >= 10'(SVV)) bl_bad++;
      if (fs_s) fs_cnt++;
    end
    n_total++;
    if (vs_low != SVS * SHT) $display("FAIL vs_width got %0d want %0d", vs_low, SVS * SHT);
    else n_pass++;
    n_total++;
    if (bl_cnt != SHV * SVV) $display("FAIL frame_visible got %0d want %0d", bl_cnt, SHV * SVV);
    else n_pass++;
    n_total++;
    if (bl_bad != 0) $display("FAIL blank_vblank got %0d want 0", bl_bad);
    else n_pass++;
    n_total++;
    if (fs_cnt != 1 || fc_s !== fc0 + 8'd1)
      $display("FAIL frame_strobe got pulses=%0d fc=%0d want pulses=1 fc=%0d",
               fs_cnt, fc_s, fc0 + 8'd1);
    else n_pass++;
  endtask

  task automatic test_frame_count_wrap();
    logic [7:0] fc0, prev_fc;
    int wraps = 0;
    fc0 = fc_s;
    for (int i = 0; i < 256 * SHT * SVT; i++) begin
      prev_fc = fc_s;
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL wrap_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL wrap_s got %h want %h", obs_s, es);
      else n_pass++;
      if (prev_fc == 8'd255 && fc_s == 8'd0) wraps++;
    end
    n_total++;
    if (fc_s !== fc0 || wraps != 1)
      $display("FAIL fc_wrap got fc=%0d wraps=%0d want fc=%0d wraps=1", fc_s, wraps, fc0);
    else n_pass++;
  endtask

  task automatic test_pix_en_toggle();
    out_t prev_d, prev_s;
    int last0 = -1, period = -1, fs_run = 0, fs_len = -1;
    for (int i = 0; i < 600; i++) begin
      prev_d = obs_d;
      prev_s = obs_s;
      cycle(i % 2 == 0);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL toggle_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL toggle_s got %h want %h", obs_s, es);
      else n_pass++;
      if (i % 2 == 1) begin
        n_total++;
        if (obs_d !== prev_d || obs_s !== prev_s)
          $display("FAIL hold got %h/%h want %h/%h", obs_d, obs_s, prev_d, prev_s);
        else n_pass++;
      end
      if (dx_s == 10'd0 && prev_s.x != 10'd0) begin
        if (last0 >= 0 && period < 0) period = i - last0;
        last0 = i;
      end
      if (fs_s) fs_run++;
      else begin
        if (fs_run > 0 && fs_len < 0) fs_len = fs_run;
        fs_run = 0;
      end
    end
    n_total++;
    if (period != 2 * SHT) $display("FAIL half_rate_line got %0d want %0d", period, 2 * SHT);
    else n_pass++;
    n_total++;
    if (fs_len != 2) $display("FAIL half_rate_strobe got %0d want 2", fs_len);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 200 && !(ms.x == 10'd5 && ms.y == 10'd3); i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL pre_reset_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL pre_reset_s got %h want %h", obs_s, es);
      else n_pass++;
    end
    n_total++;
    if ({dx_s, dy_s} !== {10'd5, 10'd3})
      $display("FAIL mid_frame got (%0d,%0d) want (5,3)", dx_s, dy_s);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (obs_d !== RST || obs_s !== RST)
      $display("FAIL async_reset got %h/%h want %h", obs_d, obs_s, RST);
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1);
      ed = q_d.pop_front();
      es = q_s.pop_front();
      n_total++;
      if (obs_d !== ed) $display("FAIL post_reset_d got %h want %h", obs_d, ed);
      else n_pass++;
      n_total++;
      if (obs_s !== es) $display("FAIL post_reset_s got %h want %h", obs_s, es);
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if ({dx_s, dy_s, fc_s, dx_d, dy_d} !== {10'd1, 10'd0, 8'd0, 10'd1, 10'd0})
          $display("FAIL restart got (%0d,%0d) fc=%0d want (1,0) fc=0", dx_s, dy_s, fc_s);
        else n_pass++;
      end
    end
  endtask

  initial begin
    md = RST;
    ms = RST;
    test_reset();
    test_line_sweep();
    test_frame_sweep();
    test_frame_count_wrap();
    test_pix_en_toggle();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
